// File: rtl/gpio_pad_pkg.sv
// gpio_pad_pkg: shared state, drive-mode and pad config types for the GPIO pad sequencer
package gpio_pad_pkg;

    typedef enum logic [2:0] {
        OFF,
        PWR_EN,
        HOLD_REL,
        IDLE,
        TRI,
        APPLY,
        RESTORE,
        HOLD
    } state_t;

    localparam logic [2:0] DM_HIZ    = 3'b000;
    localparam logic [2:0] DM_INPUT  = 3'b001;
    localparam logic [2:0] DM_STRONG = 3'b110;

    typedef struct packed {
        logic [2:0] dm;
        logic       oe;
        logic       inp_dis;
        logic       slow;
        logic       vtrip;
    } pad_cfg_t;

    localparam pad_cfg_t CFG_RST = '{dm: DM_HIZ, oe: 1'b0, inp_dis: 1'b1, slow: 1'b0, vtrip: 1'b0};

endpackage

// File: rtl/gpio_pad_seq_ctrl_in_sync.sv
// gpio_in_sync: two-flop synchroniser for pad IN with registered edge pulses
module gpio_in_sync (
    input  logic clock,
    input  logic reset_n,
    input  logic pad_in,
    output logic in_sync,
    output logic in_rise,
    output logic in_fall
);

    logic meta, prev;

    // sync chain, previous-value flop and registered edge compares
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            meta    <= 1'b0;
            in_sync <= 1'b0;
            prev    <= 1'b0;
            in_rise <= 1'b0;
            in_fall <= 1'b0;
        end else begin
            meta    <= pad_in;
            in_sync <= meta;
            prev    <= in_sync;
            in_rise <= in_sync & ~prev;
            in_fall <= ~in_sync & prev;
        end
    end

endmodule

// File: rtl/gpio_pad_seq_ctrl.sv
// gpio_pad_seq_ctrl: power-up and glitch-free reconfiguration sequencer for one GPIOv2 pad
module gpio_pad_seq_ctrl
    import gpio_pad_pkg::*;
#(
    parameter int EN_CYCLES = 16,
    parameter int SW_CYCLES = 4,
    parameter int CNT_W     = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       cfg_valid,
    output logic       cfg_ready,
    input  logic [2:0] cfg_dm,
    input  logic       cfg_oe,
    input  logic       cfg_inp_dis,
    input  logic       cfg_slow,
    input  logic       cfg_vtrip,
    input  logic       hold_req,
    input  logic       out_data,
    output logic [2:0] pad_dm,
    output logic       pad_oe_n,
    output logic       pad_inp_dis,
    output logic       pad_slow,
    output logic       pad_vtrip_sel,
    output logic       pad_enable_h,
    output logic       pad_hld_h_n,
    output logic       pad_out,
    input  logic       pad_in,
    output logic       in_sync,
    output logic       in_rise,
    output logic       in_fall,
    output logic       busy
);

    localparam logic [CNT_W-1:0] EN_LD = CNT_W'(EN_CYCLES - 1);
    localparam logic [CNT_W-1:0] SW_LD = CNT_W'(SW_CYCLES - 1);

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_ld;
    logic             accept, done;
    pad_cfg_t         shadow, cur;

    // next state, handshake and the delay to load when a state is entered
    always_comb begin
        state_n = state;
        accept  = 1'b0;
        done    = cnt == '0;
        case (state)
            OFF:      state_n = PWR_EN;
            PWR_EN:   state_n = done ? HOLD_REL : PWR_EN;
            HOLD_REL: state_n = done ? IDLE : HOLD_REL;
            IDLE: begin
                accept  = !hold_req && cfg_valid;
                state_n = hold_req ? HOLD : (cfg_valid ? TRI : IDLE);
            end
            TRI:      state_n = done ? APPLY : TRI;
            APPLY:    state_n = done ? RESTORE : APPLY;
            RESTORE:  state_n = IDLE;
            HOLD:     state_n = hold_req ? HOLD : HOLD_REL;
            default:  state_n = OFF;
        endcase
        cnt_ld = state_n == PWR_EN ? EN_LD : SW_LD;
    end

    // state register and down-counter that reloads on every state change
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= OFF;
            cnt   <= '0;
        end else begin
            state <= state_n;
            cnt   <= state_n != state ? cnt_ld : (done ? cnt : cnt - 1'b1);
        end
    end

    // shadow capture and staged pad updates: tri-state, switch mode, re-enable
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= CFG_RST;
            cur    <= CFG_RST;
        end else begin
            if (accept) begin
                shadow <= '{dm: cfg_dm, oe: cfg_oe, inp_dis: cfg_inp_dis, slow: cfg_slow, vtrip: cfg_vtrip};
                cur.oe <= 1'b0;
            end
            if (state == TRI && state_n == APPLY) begin
                cur.dm      <= shadow.dm;
                cur.inp_dis <= shadow.inp_dis;
                cur.slow    <= shadow.slow;
                cur.vtrip   <= shadow.vtrip;
            end
            if (state == RESTORE) cur.oe <= shadow.oe;
        end
    end

    assign pad_dm        = cur.dm;
    assign pad_oe_n      = ~cur.oe;
    assign pad_inp_dis   = cur.inp_dis;
    assign pad_slow      = cur.slow;
    assign pad_vtrip_sel = cur.vtrip;
    assign pad_enable_h  = state != OFF;
    assign pad_hld_h_n   = !(state inside {OFF, PWR_EN, HOLD});
    assign pad_out       = out_data;
    assign cfg_ready     = state == IDLE;
    assign busy          = state != IDLE;

    gpio_in_sync u_in_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .pad_in  (pad_in),
        .in_sync (in_sync),
        .in_rise (in_rise),
        .in_fall (in_fall)
    );

endmodule

// File: doc/gpio_pad_seq_ctrl.md
Name: gpio_pad_seq_ctrl

Overview:
Sequencing controller for one sky130 GPIOv2 pad instance. Brings the pad out of power-on in a safe order (enable, then hold release), and applies drive-mode/config changes glitch-free by tri-stating before switching DM. Also provides a hold/freeze request and a synchronised input with edge pulses. Sits between the SoC GPIO register block and the pad ring wrapper; one instance per pad.

Parameters:
EN_CYCLES, 16, cycles ENABLE_H is held high before hold release (>=1)
SW_CYCLES, 4, settle cycles for each tri-state/apply step (>=1)
CNT_W, 8, delay counter width; EN_CYCLES and SW_CYCLES must each be <= 2^CNT_W-1

Ports:
clock  in  1  single clock
reset_n  in  1  asynchronous active-low reset
cfg_valid  in  1  new config offered
cfg_ready  out  1  high only in IDLE
cfg_dm  in  3  requested drive mode
cfg_oe  in  1  requested output enable (active-high)
cfg_inp_dis  in  1  requested input disable
cfg_slow  in  1  requested slew select
cfg_vtrip  in  1  requested VTRIP_SEL
hold_req  in  1  level: freeze pad state
out_data  in  1  data to drive, passed straight to pad OUT
pad_dm  out  3  to DM
pad_oe_n  out  1  to OE_N
pad_inp_dis  out  1  to INP_DIS
pad_slow  out  1  to SLOW
pad_vtrip_sel  out  1  to VTRIP_SEL
pad_enable_h  out  1  to ENABLE_H / ENABLE_INP_H
pad_hld_h_n  out  1  to HLD_H_N
pad_out  out  1  to OUT
pad_in  in  1  from pad IN (asynchronous)
in_sync  out  1  2-flop synchronised pad_in
in_rise  out  1  one-cycle pulse on in_sync 0->1
in_fall  out  1  one-cycle pulse on in_sync 1->0
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async assert, sync deassert by caller): state OFF; pad_dm=000, pad_oe_n=1, pad_inp_dis=1, pad_slow=0, pad_vtrip_sel=0, pad_enable_h=0, pad_hld_h_n=0, cfg_ready=0, busy=1, in_sync=0, in_rise=0, in_fall=0, delay counter=0. The shadow config register resets to dm=000, oe=0, inp_dis=1, slow=0, vtrip=0.
- pad_out = out_data combinationally in every state. The pad only drives it when pad_oe_n=0.
- States and transitions:
  - OFF: one cycle after reset release -> PWR_EN. pad_enable_h=1 from PWR_EN onward.
  - PWR_EN: counts EN_CYCLES cycles -> HOLD_REL.
  - HOLD_REL: pad_hld_h_n=1 and counts SW_CYCLES -> IDLE.
  - IDLE: cfg_ready=1.
    - If hold_req=1 -> HOLD, with priority over cfg_valid in the same cycle.
    - Else if cfg_valid=1: capture all cfg_* into the shadow register (handshake completes this cycle), then -> TRI.
  - TRI: pad_oe_n forced to 1 and counts SW_CYCLES -> APPLY.
  - APPLY: pad_dm, pad_inp_dis, pad_slow and pad_vtrip_sel take the shadow values on entry; counts SW_CYCLES -> RESTORE.
  - RESTORE: pad_oe_n = ~shadow.oe, registered; one cycle -> IDLE.
  - HOLD: pad_hld_h_n=0; all other pad outputs frozen. When hold_req=0 -> HOLD_REL, which waits SW_CYCLES before IDLE.
- Latency: IDLE handshake to final pad_oe_n = 2*SW_CYCLES+2 cycles. Reset release to cfg_ready=1 = 1+EN_CYCLES+SW_CYCLES cycles.
- hold_req during TRI/APPLY/RESTORE is ignored until IDLE; sequences are never aborted.
- cfg_valid while not IDLE: not accepted; the requester keeps it asserted until cfg_ready.
- A config identical to the current one still runs the full TRI/APPLY/RESTORE sequence.
- Counter: loads target-1 on state entry, decrements, and transitions at 0. There is no wrap.
- Reset mid-sequence: all outputs return to reset values immediately (asynchronous); the sequence restarts from OFF.
- Input path: in_sync is a 2-flop synchroniser. A third flop holds the previous value; in_rise/in_fall are registered compares and are valid in every state, including HOLD.

Decomposition:
- Package gpio_pad_pkg: state enum (OFF, PWR_EN, HOLD_REL, IDLE, TRI, APPLY, RESTORE, HOLD), DM encoding constants (DM_HIZ=000, DM_INPUT=001, DM_STRONG=110), and a pad config struct {dm, oe, inp_dis, slow, vtrip}.
- One sub-module, gpio_in_sync: synchroniser plus edge detect.

Test Plan:
- Power-up, EN_CYCLES=16, SW_CYCLES=4: pad_enable_h rises at cycle 1, pad_hld_h_n rises at cycle 17, cfg_ready rises at cycle 21; pad_oe_n=1 and pad_dm=000 throughout.
- Config dm=110, oe=1 accepted at cycle T: pad_oe_n stays 1, pad_dm=110 at T+5, pad_oe_n=0 at T+10, cfg_ready=1 at T+10.
- Output enabled, then new config dm=001, oe=0: pad_oe_n=1 from T+1; pad_dm never changes while pad_oe_n=0; final pad_oe_n=1.
- hold_req and cfg_valid both high in IDLE: pad_hld_h_n=0 next cycle, cfg not accepted. After hold_req drops, pad_hld_h_n=1 and cfg_ready=1 4 cycles later; config is then accepted.
- reset_n low during APPLY: pad_dm=000, pad_oe_n=1, pad_hld_h_n=0 asynchronously; full power-up sequence repeats after release.
- pad_in toggles 0->1->0, each level held 5 cycles: in_rise pulses one cycle, 3 cycles after the edge; in_fall likewise; no double pulses.
